regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Read-side companion to the 32x32 register file. On a start pulse it walks
//  an address range on one register-file read port and streams each word out
//  over a valid/ready interface, one beat per register. Used for debug
//  readback and context dump. It never writes the register file.
// PARAMETERS
//  NUM_REGS  32  number of registers; range wraps modulo NUM_REGS
//  ADDR_W    5   register address width, clog2(NUM_REGS)
//  DATA_W    32  register data width
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       reset, asynchronous, active-low
//  start         in   1       1-cycle request; sampled only in IDLE
//  abort         in   1       synchronous cancel; wins over all other events
//  first_addr    in   ADDR_W  first register of dump; latched on accepted start
//  last_addr     in   ADDR_W  last register of dump; latched on accepted start
//  busy          out  1       high from the cycle after start until DONE exits
//  done          out  1       1-cycle pulse when the final beat is accepted
//  rf_read_addr  out  ADDR_W  to register-file read port (combinational read)
//  rf_read_data  in   DATA_W  from register-file read port
//  out_valid     out  1       beat valid
//  out_ready     in   1       sink ready; a beat transfers when valid&&ready
//  out_data      out  DATA_W  register contents
//  out_addr      out  ADDR_W  register index of this beat
//  out_last      out  1       final beat of dump
//  out_csum      out  1       beat is the checksum word (0 unless macro set)
// BEHAVIOUR
//  - Reset: state=IDLE. busy, done, out_valid, out_last and out_csum are 0.
//    out_data, out_addr, rf_read_addr and the address counter are 0.
//  - FSM states: IDLE, LOAD, SEND, DONE (+CSUM with macro).
//  - IDLE: when start=1, latch first/last, set cnt=first, go to LOAD.
//  - LOAD, 1 cycle: rf_read_addr=cnt. Register out_data<=rf_read_data,
//    out_addr<=cnt, out_last<=(cnt==last), out_valid<=1. Go to SEND.
//  - SEND: all out_* are held stable while out_valid && !out_ready.
//    On transfer: out_valid<=0. If final beat, go to DONE.
//    Otherwise cnt<=(cnt+1) mod NUM_REGS and go to LOAD.
//    Throughput is 1 beat per 2 cycles with out_ready tied high.
//  - DONE: done=1 for exactly 1 cycle, busy<=0, go to IDLE. A new start is
//    accepted on the following cycle.
//  - Range length = ((last-first) mod NUM_REGS)+1.
//    first==last gives 1 beat. first>last wraps through NUM_REGS-1 to 0.
//  - start while busy is ignored. first_addr/last_addr are don't-care
//    outside the start cycle.
//  - Data snapshot: each word is the register content in its LOAD cycle.
//    A write to that address in the same cycle is not seen (the read is
//    pre-write). A later write does not alter a beat already loaded.
//  - abort: next cycle is IDLE, with out_valid, out_last, busy and out_csum at 0.
//    No done pulse. A beat pending in that cycle is dropped. abort has priority
//    over start and over a simultaneous transfer.
//  - rf_read_addr tracks cnt in every state. Reads have no side effects.
// CONFIGURATION
//  REGDUMP_CHECKSUM_EN defined:
//   - Keep a running XOR of all transferred register words.
//     It is cleared on an accepted start.
//   - After the last register beat, move to state CSUM and send one extra beat:
//     out_data=XOR, out_addr=last, out_csum=1, out_last=1.
//   - Register beats then have out_last=0. done follows the CSUM transfer.
//  REGDUMP_CHECKSUM_EN undefined:
//   - No CSUM state. out_csum is tied to 0.
//   - out_last marks the last register beat.
// TESTING
//  1. Reset mid-dump (rst_n low in SEND), then release.
//     -> All outputs 0, state IDLE, no done pulse.
//  2. RF r0..r31 = 0x1000+i; start with first=0, last=31, ready=1.
//     -> 32 beats at addr 0..31, data 0x1000..0x101F, last only on addr 31,
//        done 1 cycle after final transfer.
//  3. start with first=30, last=1.
//     -> 4 beats in order addr 30, 31, 0, 1. out_last on addr 1.
//  4. first=5, last=5; ready low for 7 cycles after valid.
//     -> out_data, out_addr and out_last stay stable.
//     -> 1 transfer when ready rises, then done.
//  5. Pulse start again while busy; pulse abort in SEND with ready=1.
//     -> The second start has no effect.
//     -> Next cycle out_valid=0 and busy=0, no done pulse.
//     -> A new start is accepted afterwards.
//  6. Macro on, r2=0x0F, r3=0xF0, dump 2..3.
//     -> 3 beats; the third has data 0xFF, out_csum=1, out_last=1.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range on one read port and streams each word out over valid/ready.
// Optional REGDUMP_CHECKSUM_EN appends one XOR checksum beat after the last register beat.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_csum
);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DONE, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic              out_csum_q, out_csum_d;
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic xfer;
    logic last_beat;
    logic [ADDR_W-1:0] cnt_next;

    assign xfer      = out_valid_q && out_ready;
    assign last_beat = (cnt_q == last_q);
    assign cnt_next  = (cnt_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cnt_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        out_csum_d  = out_csum_q;
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = first_addr;
                    last_d  = last_addr;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                out_data_d  = rf_read_data;
                out_addr_d  = cnt_q;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = last_beat;
`endif
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d = csum_q ^ out_data_q;
`endif
                    if (last_beat) begin
`ifdef REGDUMP_CHECKSUM_EN
                        // Checksum beat is presented straight after the last register beat.
                        out_valid_d = 1'b1;
                        out_data_d  = csum_q ^ out_data_q;
                        out_addr_d  = last_q;
                        out_last_d  = 1'b1;
                        out_csum_d  = 1'b1;
                        state_d     = S_CSUM;
`else
                        state_d     = S_DONE;
`endif
                    end else begin
                        cnt_d   = cnt_next;
                        state_d = S_LOAD;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    out_csum_d  = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Cancel overrides start and any transfer in the same cycle.
        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_csum_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_csum_q  <= 1'b0;
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
            out_csum_q  <= out_csum_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign rf_read_addr = cnt_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_addr     = out_addr_q;
    assign out_last     = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    assign out_csum     = out_csum_q;
`else
    assign out_csum     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: dump expectations come from a range/XOR model over a bench-side register array.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [4:0]  first_addr, last_addr;
    logic        busy, done;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last, out_csum;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
        logic        csum;
    } beat_t;

    logic [31:0] rf [32];
    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          cyc_n    = 0;
    int          last_xfer = -10;
    logic        rdy_rand = 1'b0;
    logic        rdy_force = 1'b1;
    logic        rnd_bit = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(99) < 70);
    end

    assign out_ready    = rdy_rand ? rnd_bit : rdy_force;
    assign rf_read_data = rf[rf_read_addr];

    regfile_dump_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .out_csum(out_csum)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {27'd0, out_data, out_addr}, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", {25'd0, out_data, out_addr, out_last, out_csum}, {25'd0, e});
                end
                if (out_last) last_xfer = cyc_n;
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", 64'(cyc_n), 64'(last_xfer + 1));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: range length is ((last-first) mod 32)+1 with modular wrap of the index.
    task automatic push_dump(input int f, input int l);
        int len;
        logic [31:0] x;
        beat_t b;
        len = ((l - f + 32) % 32) + 1;
        x = 32'd0;
        for (int i = 0; i < len; i++) begin
            b.addr = 5'((f + i) % 32);
            b.data = rf[(f + i) % 32];
            b.csum = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == len - 1);
`endif
            x ^= b.data;
            exp_q.push_back(b);
        end
`ifdef REGDUMP_CHECKSUM_EN
        b.data = x;
        b.addr = 5'(l);
        b.last = 1'b1;
        b.csum = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    task automatic do_start(input int f, input int l);
        if (!busy) push_dump(f, l);
        start = 1'b1;
        first_addr = 5'(f);
        last_addr = 5'(l);
        cyc();
        start = 1'b0;
        first_addr = 5'($urandom);
        last_addr = 5'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            cyc();
        end
        chk("done_count", 64'(done_cnt), 64'(d0 + 1));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (out_valid) break;
            cyc();
        end
        chk("valid_seen", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_last"}, {63'd0, out_last}, 64'd0);
        chk({tag, "_csum"}, {63'd0, out_csum}, 64'd0);
        chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
        chk({tag, "_addr"}, {59'd0, out_addr}, 64'd0);
        chk({tag, "_rfaddr"}, {59'd0, rf_read_addr}, 64'd0);
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    initial begin
        int d0;
        logic [31:0] s_data;
        logic [4:0]  s_addr;
        logic        s_last;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        first_addr = '0; last_addr = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        repeat (3) cyc();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // Reset in the middle of a dump.
        do_start(3, 20);
        wait_valid(10);
        repeat (3) cyc();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        exp_q.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("midreset_no_done", 64'(done_cnt), 64'(d0));

        // Full 0..31 dump, ready tied high.
        d0 = done_cnt;
        do_start(0, 31);
        wait_done(d0, 200);

        // Wrapping range.
        randomize_rf();
        d0 = done_cnt;
        do_start(30, 1);
        wait_done(d0, 50);

        // Single beat held under backpressure.
        rdy_force = 1'b0;
        d0 = done_cnt;
        do_start(5, 5);
        wait_valid(10);
        s_data = out_data; s_addr = out_addr; s_last = out_last;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("hold", {26'd0, out_valid, out_data, out_addr},
                {26'd0, 1'b1, s_data, s_addr});
            chk("hold_last", {63'd0, out_last}, {63'd0, s_last});
        end
        rdy_force = 1'b1;
        wait_done(d0, 20);

        // Start while busy is ignored.
        d0 = done_cnt;
        do_start(8, 12);
        cyc();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
        cyc();
        start = 1'b0;
        wait_done(d0, 40);

        // Abort during SEND with a simultaneous transfer.
        d0 = done_cnt;
        do_start(8, 12);
        wait_valid(10);
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_last", {63'd0, out_last}, 64'd0);
        exp_q.delete();
        repeat (3) cyc();
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        d0 = done_cnt;
        do_start(0, 2);
        wait_done(d0, 20);

        // Small range used for checksum observation.
        rf[2] = 32'h0F; rf[3] = 32'hF0;
        d0 = done_cnt;
        do_start(2, 3);
        wait_done(d0, 20);

        // Randomized dumps with random backpressure and stray starts.
        rdy_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            randomize_rf();
            d0 = done_cnt;
            do_start($urandom_range(31), $urandom_range(31));
            if ($urandom_range(1) == 1 && busy) begin
                start = 1'b1;
                first_addr = 5'($urandom);
                last_addr = 5'($urandom);
                cyc();
                start = 1'b0;
            end
            wait_done(d0, 400);
            repeat ($urandom_range(2)) cyc();
        end
        rdy_rand = 1'b0;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
